uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Serializes bytes from the TX FIFO onto the UART TX line as 8N1 (or 8N2) frames. Sits directly downstream of the TX FIFO that Frame_Builder fills. Pops one byte at a time through a first-word-fall-through read handshake, honours CTS flow control at byte boundaries, and streams back-to-back bytes with no idle gap. Reports busy/done status to the top-level status registers.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD_RATE, 115200, line rate; BAUD_DIV = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, which gives 868 at the defaults.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- clk  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_fifo_data  input  8  head of the TX FIFO; valid whenever tx_fifo_empty=0.
- tx_fifo_empty  input  1  TX FIFO holds no bytes.
- tx_fifo_read  output  1  one-cycle pop strobe; the byte is consumed on the same edge.
- cts_n  input  1  clear-to-send, active-low, asynchronous to clk.
- uart_tx  output  1  serial line; idles high.
- tx_busy  output  1  high from the cycle after a pop until the last stop-bit cycle, inclusive.
- tx_done  output  1  one-cycle pulse after each byte's final stop bit.

## Operation
- Elaboration-time checks:
  - BAUD_DIV < 2 is a fatal error.
  - STOP_BITS outside {1,2} is a fatal error.
- cts_n passes through a 2-flop synchronizer (cts_sync_n). "cts_ok" means cts_sync_n=0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx=1.
  - When tx_fifo_empty=0 and cts_ok: assert tx_fifo_read (combinational from registered state and inputs), load tx_fifo_data into shift_reg, clear baud_cnt and bit_cnt, go to START.
- START:
  - uart_tx=0 for BAUD_DIV cycles, then go to DATA.
- DATA:
  - uart_tx=shift_reg[0] (LSB first).
  - Each time baud_cnt reaches BAUD_DIV-1, shift right and increment bit_cnt.
  - After 8 bits, go to STOP.
- STOP:
  - uart_tx=1 for STOP_BITS×BAUD_DIV cycles.
  - On the final cycle, pulse tx_done on the next edge.
  - If tx_fifo_empty=0 and cts_ok in that final cycle: assert tx_fifo_read, load the byte, go directly to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- CTS is sampled only at byte boundaries, i.e. in IDLE or the final STOP cycle. Deasserting CTS mid-byte never truncates the byte.
- Counter widths:
  - baud_cnt is $clog2(BAUD_DIV) bits and wraps to 0 at BAUD_DIV-1.
  - bit_cnt is 3 bits.
  - A stop counter of 1 bit tracks the second stop bit.
- tx_fifo_read is never asserted while tx_fifo_empty=1. Popping an empty FIFO is impossible by construction.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: uart_tx=1, tx_fifo_read=0, tx_busy=0, tx_done=0.
  - Internal: shift_reg=0, all counters 0, cts synchronizer=1 (not clear).
- uart_tx is registered. If the pop occurs in cycle N, the start bit begins at edge N+1.
- One byte occupies exactly (9+STOP_BITS)×BAUD_DIV cycles on the line.
- Pop-to-tx_done latency is (9+STOP_BITS)×BAUD_DIV cycles.
- Back-to-back bytes: the next start bit follows the last stop-bit cycle with zero gap. tx_busy stays high and tx_done still pulses for each byte.
- CTS latency: a change on cts_n affects the pop decision 2 cycles later.
- Reset asserted mid-byte: uart_tx goes to 1 immediately (asynchronous). The in-flight byte is lost; the FIFO is not re-read.
- A tx_fifo_empty deassertion in the same cycle as the final STOP cycle is honoured (back-to-back pop).

## Structure
- Shared package uart_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - the function calc_baud_div(clk_hz, baud).
- The RX side reuses the same package.
- One sub-module, uart_baud_gen: a counter with a sync clear that emits a bit_end strobe every BAUD_DIV cycles. It is cleared on every pop.
- The 2-flop synchronizer is inline.

## Test plan
Test parameters: CLK_FREQ_HZ=100_000_000, BAUD_RATE=10_000_000, giving BAUD_DIV=10.
- Single byte 0xA5, cts_n=0.
  - Expect one tx_fifo_read.
  - Line: 0, then 1,0,1,0,0,1,0,1, then 1, each level held 10 cycles.
  - tx_done pulses 100 cycles after the pop.
- FIFO preloaded with 0x5A, 0x01, 0xFF, STOP_BITS=1.
  - Three pops; the second and third start bits immediately follow the previous stop bit.
  - Total 300 cycles; tx_busy is continuous; three tx_done pulses.
- cts_n=1 with FIFO non-empty.
  - No pop and uart_tx=1 for 50 cycles.
  - Drop cts_n: pop occurs exactly 2 cycles later.
  - Raise cts_n mid-byte: the byte completes and no further pop occurs.
- STOP_BITS=2, byte 0x00.
  - Line low for 90 cycles, then high for 20.
  - tx_done 110 cycles after the pop.
- Reset pulsed at cycle 45 of a byte.
  - uart_tx=1 asynchronously; tx_busy=0.
  - After release with an empty FIFO, no pop occurs and the line stays high.
- tx_fifo_empty=1 throughout.
  - tx_fifo_read is never asserted and uart_tx stays 1 for 1000 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and baud divisor math.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Round-to-nearest clock cycles per bit.
  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO read handshake, flow control and line/status signals of the UART transmitter.
interface uart_tx_serializer_if;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_empty;
  logic       tx_fifo_read;
  logic       cts_n;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    input  tx_fifo_data, tx_fifo_empty, cts_n,
    output tx_fifo_read, uart_tx, tx_busy, tx_done
  );

  modport slave (
    output tx_fifo_data, tx_fifo_empty, cts_n,
    input  tx_fifo_read, uart_tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_end strobes on the last cycle of every BAUD_DIV-cycle bit.
module uart_baud_gen #(
  parameter int BAUD_DIV = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt;

  assign bit_end = (baud_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                baud_cnt <= '0;
    else if (clear || bit_end) baud_cnt <= '0;
    else                       baud_cnt <= baud_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 transmitter fed by a first-word-fall-through FIFO, CTS checked only between bytes.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_serializer_if.master  bus
);
  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE);

  if (BAUD_DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx_serializer: BAUD_DIV must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  tx_state_t  state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic [1:0] cts_sync_n;
  logic       line_q, line_nxt;
  logic       done_q, done_nxt;
  logic       pop, bit_end, stop_last, cts_ok, pop_ok;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (pop),
    .bit_end (bit_end)
  );

  assign cts_ok    = ~cts_sync_n[1];
  assign pop_ok    = ~bus.tx_fifo_empty & cts_ok;
  assign stop_last = bit_end && (stop_cnt == 1'(STOP_BITS - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (pop_ok) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:  if (stop_last) begin
               done_nxt  = 1'b1;
               // Byte boundary: chain straight into the next start bit if allowed.
               pop       = pop_ok;
               state_nxt = pop_ok ? START : IDLE;
             end
      default: state_nxt = IDLE;
    endcase

    shift_nxt = shift_reg;
    if (pop)                           shift_nxt = bus.tx_fifo_data;
    else if (state == DATA && bit_end) shift_nxt = {1'b0, shift_reg[7:1]};

    // The line is registered, so it follows the state being entered.
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift_nxt[0];
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      cts_sync_n <= 2'b11;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      cts_sync_n <= {cts_sync_n[0], bus.cts_n};
      line_q     <= line_nxt;
      done_q     <= done_nxt;
      if (pop)                           bit_cnt <= '0;
      else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
      if (pop)                           stop_cnt <= 1'b0;
      else if (state == STOP && bit_end) stop_cnt <= ~stop_cnt;
    end
  end

  assign bus.tx_fifo_read = pop;
  assign bus.uart_tx      = line_q;
  assign bus.tx_busy      = (state != IDLE);
  assign bus.tx_done      = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer: 1- and 2-stop-bit instances against a frame-queue model.
module tb_uart_tx_serializer;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 10_000_000;
  localparam int DIV    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_serializer_if bus1 ();
  uart_tx_serializer_if bus2 ();

  // FIFO model: bench writes wr_ptr, pops advance rd_ptr one edge after being seen.
  logic [7:0] fifo_mem [1024];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         sel    = 0;
  logic       cts_n  = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr % 1024];

  assign bus1.tx_fifo_data  = fifo_data;
  assign bus1.tx_fifo_empty = fifo_empty | (sel != 0);
  assign bus1.cts_n         = cts_n;
  assign bus2.tx_fifo_data  = fifo_data;
  assign bus2.tx_fifo_empty = fifo_empty | (sel != 1);
  assign bus2.cts_n         = cts_n;

  uart_tx_serializer #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1.master));
  uart_tx_serializer #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2.master));

  logic rd, line, busy, done;
  assign rd   = (sel == 1) ? bus2.tx_fifo_read : bus1.tx_fifo_read;
  assign line = (sel == 1) ? bus2.uart_tx      : bus1.uart_tx;
  assign busy = (sel == 1) ? bus2.tx_busy      : bus1.tx_busy;
  assign done = (sel == 1) ? bus2.tx_done      : bus1.tx_done;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: every pop schedules the byte's whole frame as a queue of
  // per-cycle line levels; a byte boundary is when that queue is empty or on its last entry.
  logic exp_q[$];
  int   cyc = 0, pops = 0, done_cnt = 0, pop_cyc = 0, done_cyc = 0;
  int   busy_cyc = 0, low_cyc = 0;
  int   line_err = 0, busy_err = 0, done_err = 0, pop_err = 0;
  logic h1 = 1'b1, h2 = 1'b1, done_pend = 1'b0;

  always @(negedge clk) begin
    logic exp_line, exp_pop;
    int   sb;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      h1 = 1'b1; h2 = 1'b1; done_pend = 1'b0;
    end else begin
      sb       = (sel == 1) ? 2 : 1;
      exp_line = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
      exp_pop  = !fifo_empty && !h2 && (exp_q.size() <= 1);
      if (line !== exp_line)            line_err++;
      if (busy !== (exp_q.size() != 0)) busy_err++;
      if (done !== done_pend)           done_err++;
      if (rd   !== exp_pop)             pop_err++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (busy === 1'b1) busy_cyc++;
      if (line === 1'b0) low_cyc++;
      done_pend = (exp_q.size() == 1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (rd === 1'b1) begin
        if (fifo_empty) pop_err++;
        pops++;
        pop_cyc = cyc;
        for (int i = 0; i < DIV; i++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < DIV; i++) exp_q.push_back(fifo_data[b]);
        for (int i = 0; i < sb * DIV; i++) exp_q.push_back(1'b1);
      end
      h2 = h1;
      h1 = cts_n;
    end
  end

  always @(posedge clk) begin
    #1;
    rd_ptr = pops;
  end

  int line_b = 0, busy_b = 0, done_b = 0, pop_b = 0;

  task automatic check_model(input string tag);
    chk({tag, ".line"}, line_err - line_b, 0);
    chk({tag, ".busy"}, busy_err - busy_b, 0);
    chk({tag, ".done"}, done_err - done_b, 0);
    chk({tag, ".pop"},  pop_err  - pop_b,  0);
    line_b = line_err; busy_b = busy_err; done_b = done_err; pop_b = pop_err;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic wait_dones(input string tag, input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin tick(1); k++; end
    chk(tag, done_cnt, target);
  endtask

  task automatic wait_pop(input string tag, input int base, input int budget);
    int k = 0;
    while (pops <= base && k < budget) begin tick(1); k++; end
    chk(tag, pops, base + 1);
  endtask

  task automatic run_random(input string tag, input int iters);
    int k = 0;
    for (int it = 0; it < iters; it++) begin
      int n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      cts_n = ($urandom_range(0, 3) == 0);
      tick($urandom_range(5, 120));
    end
    cts_n = 1'b0;
    while ((!fifo_empty || busy) && k < 5000) begin tick(1); k++; end
    chk({tag, ".drain"}, {31'd0, (!fifo_empty || busy)}, 0);
    tick(5);
    check_model(tag);
  endtask

  initial begin
    int b_pop, b_done, b_low, b_busy, p0, cts_cyc, pc;
    logic [7:0] rb;

    tick(3);
    chk("rst.uart_tx", line, 1);
    chk("rst.read",    rd,   0);
    chk("rst.busy",    busy, 0);
    chk("rst.done",    done, 0);
    rst_n = 1'b1;
    tick(5);

    // Single byte 0xA5: start + four zero data bits are low.
    cts_n = 1'b0;
    tick(3);
    b_pop = pops; b_done = done_cnt; b_low = low_cyc;
    push(8'hA5);
    wait_dones("s1.done", b_done + 1, 400);
    tick(5);
    chk("s1.pops", pops - b_pop, 1);
    // Strobe cycle, then 100 line cycles, then the done cycle.
    chk("s1.latency", done_cyc - pop_cyc, 10 * DIV + 1);
    chk("s1.low", low_cyc - b_low, (1 + 8 - $countones(8'hA5)) * DIV);
    check_model("s1");

    // Three preloaded bytes stream back to back.
    b_pop = pops; b_done = done_cnt; b_busy = busy_cyc;
    push(8'h5A); push(8'h01); push(8'hFF);
    wait_pop("s2.first_pop", b_pop, 50);
    p0 = pop_cyc;
    wait_dones("s2.done", b_done + 3, 700);
    tick(5);
    chk("s2.pops", pops - b_pop, 3);
    chk("s2.span", done_cyc - p0, 3 * 10 * DIV + 1);
    chk("s2.busy_cycles", busy_cyc - b_busy, 3 * 10 * DIV);
    check_model("s2");

    // CTS hold-off, 2-cycle CTS latency, and mid-byte deassertion.
    cts_n = 1'b1;
    tick(5);
    b_pop = pops; b_done = done_cnt; b_low = low_cyc;
    push(8'h3C);
    tick(50);
    chk("s3.held_pops", pops - b_pop, 0);
    chk("s3.held_low",  low_cyc - b_low, 0);
    cts_n = 1'b0;
    cts_cyc = cyc + 1;
    wait_pop("s3.pop", b_pop, 20);
    chk("s3.cts_latency", pop_cyc - cts_cyc, 2);
    push(8'hC3);
    tick(30);
    cts_n = 1'b1;
    wait_dones("s3.done", b_done + 1, 300);
    tick(150);
    chk("s3.pops", pops - b_pop, 1);
    chk("s3.dones", done_cnt - b_done, 1);
    check_model("s3");
    wr_ptr = rd_ptr;
    cts_n = 1'b0;
    tick(5);

    // Two stop bits, byte 0x00.
    sel = 1;
    tick(3);
    b_pop = pops; b_done = done_cnt; b_low = low_cyc;
    push(8'h00);
    wait_dones("s4.done", b_done + 1, 400);
    tick(5);
    chk("s4.pops", pops - b_pop, 1);
    chk("s4.latency", done_cyc - pop_cyc, 11 * DIV + 1);
    chk("s4.low", low_cyc - b_low, 9 * DIV);
    check_model("s4");

    // Reset during data bit 3 (forced low so the async return to idle is visible).
    sel = 0;
    tick(3);
    b_pop = pops;
    rb = 8'($urandom_range(0, 255)) & 8'hF7;
    push(rb);
    wait_pop("s5.pop", b_pop, 20);
    pc = pop_cyc;
    while (cyc < pc + 45) begin @(negedge clk); #1; end
    chk("s5.line_before", line, 0);
    rst_n = 1'b0;
    #1;
    chk("s5.async_line", line, 1);
    chk("s5.async_busy", busy, 0);
    tick(3);
    rst_n = 1'b1;
    b_low = low_cyc;
    tick(200);
    chk("s5.pops", pops - b_pop, 1);
    chk("s5.low_after", low_cyc - b_low, 0);
    check_model("s5");

    // Empty FIFO for 1000 cycles.
    b_pop = pops; b_low = low_cyc;
    tick(1000);
    chk("s6.pops", pops - b_pop, 0);
    chk("s6.low",  low_cyc - b_low, 0);
    check_model("s6");

    run_random("rnd1", 25);
    sel = 1;
    tick(3);
    run_random("rnd2", 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
